dht11_sensor_model: RTL



---
 rtl/dht11_sensor_model.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model: sensor-side responder for the DHT11 single-wire bus.
// It detects a host start pulse and answers with the response preamble
// and a 40-bit frame (hum_int, hum_dec, temp_int, temp_dec, checksum,
// MSB first). The bus is driven only through the open-drain enable
// dht_drive_low.
// Optional build macro DHT11_CRC_INJECT_EN adds input crc_err_inj. When
// that input is sampled high at start acceptance, the transmitted checksum
// is bitwise inverted.
module dht11_sensor_model #(
  parameter int unsigned TICKS_PER_US  = 1,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned RESP_LOW_US   = 80,
  parameter int unsigned RESP_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70,
  parameter int unsigned GUARD_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
`ifdef DHT11_CRC_INJECT_EN
  ,
  input  logic       crc_err_inj
`endif
);

  localparam logic [31:0] START_TICKS  = 32'(START_MIN_US * TICKS_PER_US);
  localparam logic [31:0] DELAY_TICKS  = 32'(RESP_DELAY_US * TICKS_PER_US);
  localparam logic [31:0] RLOW_TICKS   = 32'(RESP_LOW_US * TICKS_PER_US);
  localparam logic [31:0] RHIGH_TICKS  = 32'(RESP_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] BLOW_TICKS   = 32'(BIT_LOW_US * TICKS_PER_US);
  localparam logic [31:0] BIT0_TICKS   = 32'(BIT0_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] BIT1_TICKS   = 32'(BIT1_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] GUARD        = 32'(GUARD_TICKS);

  typedef enum logic [3:0] {
    IDLE,
    HOST_LOW,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [39:0] frame_q, frame_d;
  logic        sync1_q, sync2_q;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        inj;
  logic [7:0]  csum;
  logic [31:0] bit_high_len;
  logic        line;

`ifdef DHT11_CRC_INJECT_EN
  assign inj = crc_err_inj;
`else
  assign inj = 1'b0;
`endif

  assign csum         = hum_int + hum_dec + temp_int + temp_dec;
  assign bit_high_len = frame_q[39] ? BIT1_TICKS : BIT0_TICKS;
  assign line         = sync2_q;

  // Two-flop synchronizer for the raw bus level; the idle bus reads high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= dht_in;
      sync2_q <= sync1_q;
    end
  end

  // State, counters, frame shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state logic: each timed phase holds for exactly its tick count,
  // and the tick counter restarts at zero on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line) state_d = HOST_LOW;
      end

      // The low sample that moved us out of IDLE is the first low tick,
      // so HOST_LOW has seen cnt_q+1 low ticks when the line rises.
      HOST_LOW: begin
        if (line) begin
          cnt_d = '0;
          if (cnt_q >= START_TICKS - 32'd1) begin
            state_d = RESP_DELAY;
            frame_d = {hum_int, hum_dec, temp_int, temp_dec, csum ^ {8{inj}}};
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q >= START_TICKS - 32'd1) begin
          cnt_d = cnt_q;
        end
      end

      RESP_DELAY: begin
        if (cnt_q == DELAY_TICKS - 32'd1) begin
          state_d = RESP_LOW;
          cnt_d   = '0;
        end
      end

      RESP_LOW: begin
        if (cnt_q == RLOW_TICKS - 32'd1) begin
          state_d = RESP_HIGH;
          cnt_d   = '0;
        end
      end

      // The guard masks the synchronizer delay after our own release.
      RESP_HIGH: begin
        if (cnt_q >= GUARD && !line) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == RHIGH_TICKS - 32'd1) begin
          state_d   = BIT_LOW;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end

      BIT_LOW: begin
        if (cnt_q == BLOW_TICKS - 32'd1) begin
          state_d = BIT_HIGH;
          cnt_d   = '0;
        end
      end

      // The current bit is always frame_q[39]; the frame shifts left per bit.
      BIT_HIGH: begin
        if (cnt_q >= GUARD && !line) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == bit_high_len - 32'd1) begin
          cnt_d   = '0;
          frame_d = {frame_q[38:0], 1'b0};
          if (bit_idx_q == 6'd39) begin
            state_d = END_LOW;
          end else begin
            state_d   = BIT_LOW;
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end

      END_LOW: begin
        if (cnt_q == BLOW_TICKS - 32'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track state_q.
  always_comb begin
    drive_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
    busy_d  = (state_d != IDLE) && (state_d != HOST_LOW);
  end

  assign dht_drive_low = drive_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_abort   = abort_q;

endmodule
